mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port unified instruction/data memory between two requesters: the instruction-fetch path and the load/store path of the RISC-V core.
- Holds each access until the memory handshakes, returns read data with a one-cycle valid pulse, and generates a stall for the core while either requester is waiting.
- Sits between the PC/fetch logic, the register-file/ALU/data-memory datapath, and the memory macro. This lets the core run against memories with multi-cycle latency.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, address width.
- MAX_D_STREAK, 4, consecutive data grants allowed while a fetch waits.
- TIMEOUT_CYCLES, 255, watchdog limit in BUSY (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- if_req  in  1  fetch request; held high until if_rvalid.
- if_addr  in  ADDR_WIDTH  fetch address (PC); stable while if_req is high.
- if_rdata  out  DATA_WIDTH  fetched instruction, registered.
- if_rvalid  out  1  one-cycle pulse; if_rdata is valid.
- d_req  in  1  load/store request; held high until d_rvalid.
- d_we  in  1  1 = store.
- d_addr  in  ADDR_WIDTH  byte address (ALUResult).
- d_wdata  in  DATA_WIDTH  store data.
- d_ctrl  in  3  AddressingControl encoding: byte/half/word, signed/unsigned.
- d_rdata  out  DATA_WIDTH  load data, registered.
- d_rvalid  out  1  one-cycle pulse; d_rdata valid, or store complete.
- mem_req  out  1  access active.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_WIDTH  access address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_ctrl  out  3  addressing control forwarded to memory; 3'b010 (word) for fetches.
- mem_rdata  in  DATA_WIDTH  memory read data.
- mem_ready  in  1  access completes in this cycle.
- stall  out  1  core must freeze PC and pipeline registers.
- err  out  1  sticky timeout flag; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- Reset (rst == 0 at a clk edge), applied from any state including mid-access:
  - state returns to IDLE; streak counter clears; err clears.
  - all outputs go to 0: mem_*, if_/d_rdata, if_/d_rvalid. stall = 0.
  - no rvalid is produced for an aborted access.
- IDLE:
  - d_req only: latch d_addr/d_wdata/d_we/d_ctrl, go to BUSY_D.
  - if_req only: latch if_addr, go to BUSY_I.
  - Both requesting: data wins unless streak == MAX_D_STREAK, in which case fetch wins.
- BUSY_x:
  - mem_req = 1 with latched fields, held stable.
  - On mem_ready == 1: capture mem_rdata into if_rdata or d_rdata, go to RESP. Store cycles capture nothing.
- RESP:
  - Pulse the rvalid of the owner for exactly one cycle; mem_req = 0.
  - No arbitration in this cycle; return to IDLE.
  - The requester deasserts req in its rvalid cycle.
- Latency: request seen in cycle N, with mem_ready high in N+1, gives rvalid in N+2. Peak throughput is one access per 3 cycles.
- Streak counter:
  - Increments on a data grant while if_req is high; saturates at MAX_D_STREAK.
  - Clears on any fetch grant, or on a data grant with if_req low.
- stall = (if_req & ~if_rvalid) | (d_req & ~d_rvalid).
- if_rdata and d_rdata hold their last captured value until the next capture.
- mem_ready high outside BUSY is ignored.
- d_req changing while BUSY_I does not affect the in-flight fetch.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - Watchdog counts cycles spent in BUSY_x; the count resets on entering BUSY.
  - When the count reaches TIMEOUT_CYCLES without mem_ready: drop mem_req, go to RESP, return rdata = 32'h0000_0013 (NOP) for a fetch or 0 for data, and set err.
  - err stays set until reset.
- ARB_TIMEOUT_EN undefined: BUSY waits indefinitely; err is constant 0; no watchdog logic is present.

Decomposition:
- Package mem_arb_pkg: arb_state_t enum (IDLE, BUSY_I, BUSY_D, RESP), addressing-control localparams (LB, LH, LW, LBU, LHU, SB, SH, SW), and the NOP_INSTR constant.
- Sub-module arb_watchdog (counter, clear, terminal-count flag), instantiated only under ARB_TIMEOUT_EN.
- The streak counter stays inline.

Test Plan:
- Fetch only: if_req = 1, if_addr = 0x0000_0004, mem_ready high on the first BUSY cycle, mem_rdata = 0x0050_0093 -> if_rvalid pulses 2 cycles after the request with if_rdata = 0x0050_0093; stall falls with if_rvalid.
- Simultaneous requests: if_req = d_req = 1, MAX_D_STREAK = 4, d_we = 1, d_addr = 0x100, d_wdata = 0xDEAD_BEEF, d_ctrl = SW -> data granted first (mem_we = 1, mem_ctrl = 3'b010); fetch granted next.
- Starvation: d_req held high for 6 back-to-back loads while if_req is high -> exactly 4 data grants, then one fetch grant, then data resumes.
- Wait states: mem_ready held low for 5 cycles -> mem_addr/mem_wdata stable throughout; rvalid arrives 7 cycles after the request; stall stays high throughout.
- Reset mid-access: rst = 0 during BUSY_D -> next cycle mem_req = 0, no d_rvalid, state IDLE, streak = 0.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES = 8 and mem_ready never asserted on a fetch -> if_rvalid after the timeout with if_rdata = 0x0000_0013, err = 1 and sticky.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Addressing-control codes follow the RISC-V funct3 load/store encoding.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// BUSY-state watchdog for mem_arbiter; compiled only when ARB_TIMEOUT_EN is defined.
// Counts cycles while not cleared and flags the last permitted cycle.
`ifdef ARB_TIMEOUT_EN
module arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tc
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            count <= '0;
        end else if (count != CW'(LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    // Asserted during the LIMIT-th cycle since the clear was released.
    assign tc = (count == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned MAX_D_STREAK   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_rvalid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [2:0]            d_ctrl,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_rvalid,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [2:0]            mem_ctrl,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  stall,
    output logic                  err
);

    localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    arb_state_t state, state_nx;

    logic                  grant_d;
    logic                  grant_i;
    logic                  timeout;
    logic                  owner_d;
    logic [STREAK_W-1:0]   streak;
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [2:0]            lat_ctrl;

`ifdef ARB_TIMEOUT_EN
    logic busy;
    logic wd_tc;
    logic err_q;

    assign busy = (state == BUSY_I) || (state == BUSY_D);

    arb_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk  (clk),
        .rst  (rst),
        .clear(!busy),
        .tc   (wd_tc)
    );

    assign timeout = busy && wd_tc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (timeout && !mem_ready) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        grant_d  = 1'b0;
        grant_i  = 1'b0;
        unique case (state)
            IDLE: begin
                // Data has priority until it has starved a waiting fetch long enough.
                if (d_req && !(if_req && streak == STREAK_MAX)) begin
                    grant_d  = 1'b1;
                    state_nx = BUSY_D;
                end else if (if_req) begin
                    grant_i  = 1'b1;
                    state_nx = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready || timeout) begin
                    state_nx = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = (state == BUSY_I) || (state == BUSY_D);
        mem_we    = (state == BUSY_D) && lat_we;
        if_rvalid = (state == RESP) && !owner_d;
        d_rvalid  = (state == RESP) && owner_d;
        stall     = rst && ((if_req && !if_rvalid) || (d_req && !d_rvalid));
    end

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign mem_ctrl  = lat_ctrl;

    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_d   <= 1'b0;
            streak    <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_ctrl  <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if (grant_d) begin
                owner_d   <= 1'b1;
                lat_we    <= d_we;
                lat_addr  <= d_addr;
                lat_wdata <= d_wdata;
                lat_ctrl  <= d_ctrl;
                if (!if_req) begin
                    streak <= '0;
                end else if (streak != STREAK_MAX) begin
                    streak <= streak + 1'b1;
                end
            end else if (grant_i) begin
                owner_d   <= 1'b0;
                lat_we    <= 1'b0;
                lat_addr  <= if_addr;
                lat_wdata <= '0;
                lat_ctrl  <= LW;
                streak    <= '0;
            end

            if (state == BUSY_I) begin
                if (mem_ready) begin
                    if_rdata <= mem_rdata;
                end else if (timeout) begin
                    if_rdata <= DATA_WIDTH'(NOP_INSTR);
                end
            end

            if (state == BUSY_D && !lat_we) begin
                if (mem_ready) begin
                    d_rdata <= mem_rdata;
                end else if (timeout) begin
                    d_rdata <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner cases,
// and a randomized run against a transaction-level memory/arbitration model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned MAXS = 4;
    localparam int unsigned TOC  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_rvalid;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_ctrl;
    logic [31:0] d_rdata;
    logic        d_rvalid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_ctrl;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [31:0] last_i;
    logic [31:0] last_d;

    always #5 clk = ~clk;

    mem_arbiter #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .MAX_D_STREAK  (MAXS),
        .TIMEOUT_CYCLES(TOC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_rvalid(if_rvalid),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ctrl   (d_ctrl),
        .d_rdata  (d_rdata),
        .d_rvalid (d_rvalid),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ctrl (mem_ctrl),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .stall    (stall),
        .err      (err)
    );

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  ctrl;
        logic [31:0] rdata;
        int          waits;
        logic [2:0]  exp_ctrl;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic clear_inputs();
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        d_ctrl    = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        next_cycle();
        rst    = 1'b1;
        last_i = '0;
        last_d = '0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        clear_inputs();
        if (v.is_d) begin
            d_req   = 1'b1;
            d_we    = v.we;
            d_addr  = v.addr;
            d_wdata = v.wdata;
            d_ctrl  = v.ctrl;
        end else begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end
        mem_rdata = v.rdata;
        for (int k = 0; k <= v.exp_lat; k++) begin
            mem_ready = (k == v.waits + 1);
            settle();
            chk({tag, ".mem_req"}, mem_req, (k >= 1 && k <= v.waits + 1));
            if (k >= 1 && k <= v.waits + 1) begin
                chk({tag, ".mem_addr"}, mem_addr, v.addr);
                chk({tag, ".mem_we"}, mem_we, v.we);
                chk({tag, ".mem_ctrl"}, mem_ctrl, v.exp_ctrl);
                if (v.we) chk({tag, ".mem_wdata"}, mem_wdata, v.wdata);
            end
            chk({tag, ".stall"}, stall, (k < v.exp_lat));
            chk({tag, ".if_rvalid"}, if_rvalid, (!v.is_d && k == v.exp_lat));
            chk({tag, ".d_rvalid"}, d_rvalid, (v.is_d && k == v.exp_lat));
            if (k == v.exp_lat) begin
                if (!v.is_d) last_i = v.rdata;
                else if (!v.we) last_d = v.rdata;
                if_req = 1'b0;
                d_req  = 1'b0;
            end
            chk({tag, ".if_rdata"}, if_rdata, last_i);
            chk({tag, ".d_rdata"}, d_rdata, last_d);
            next_cycle();
        end
        mem_ready = 1'b0;
        settle();
        chk({tag, ".idle_mem_req"}, mem_req, 1'b0);
        next_cycle();
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        logic [31:0] mem[16];
        logic [8:0]  seq;
        int          ng;
        bit          prev;
        int          lat;
        int          act, resp, streak, busy_n;
        bit          ip, dp, dwe, ewe;
        logic [31:0] ia, da, dwd, ea, ewd;
        logic [2:0]  dctl, ectl;

        // is_d we addr wdata ctrl rdata waits exp_ctrl exp_lat
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0, LW, 32'h0050_0093, 0, 3'b010, 2};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, LW, 32'h1234_5678, 0, 3'b010, 2};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, SW, 32'hBAD0_BAD0, 5, 3'b010, 7};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0103, 32'h0, LBU, 32'h0000_00A5, 2, 3'b100, 4};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0, LW, 32'h0000_0113, 5, 3'b010, 7};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0041, 32'h0000_0077, SB, 32'hBAD1_BAD1, 1, 3'b000, 3};

        // Reset with requests pending: everything must read zero.
        rst = 1'b0;
        clear_inputs();
        if_req = 1'b1;
        d_req  = 1'b1;
        last_i = '0;
        last_d = '0;
        next_cycle();
        next_cycle();
        settle();
        chk("rst.mem_req", mem_req, 1'b0);
        chk("rst.mem_we", mem_we, 1'b0);
        chk("rst.mem_addr", mem_addr, 32'h0);
        chk("rst.mem_wdata", mem_wdata, 32'h0);
        chk("rst.mem_ctrl", mem_ctrl, 3'b000);
        chk("rst.if_rdata", if_rdata, 32'h0);
        chk("rst.d_rdata", d_rdata, 32'h0);
        chk("rst.if_rvalid", if_rvalid, 1'b0);
        chk("rst.d_rvalid", d_rvalid, 1'b0);
        chk("rst.stall", stall, 1'b0);
        chk("rst.err", err, 1'b0);
        clear_inputs();
        next_cycle();
        rst = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Simultaneous requests: store wins, fetch follows.
        clear_inputs();
        if_req = 1'b1; if_addr = 32'h0000_0008;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_ctrl = SW;
        mem_rdata = 32'h0000_0113;
        settle();
        chk("sim.stall0", stall, 1'b1);
        next_cycle();
        mem_ready = 1'b1;
        settle();
        chk("sim.d_mem_req", mem_req, 1'b1);
        chk("sim.d_mem_we", mem_we, 1'b1);
        chk("sim.d_mem_ctrl", mem_ctrl, 3'b010);
        chk("sim.d_mem_addr", mem_addr, 32'h100);
        chk("sim.d_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        next_cycle();
        mem_ready = 1'b0;
        settle();
        chk("sim.d_rvalid", d_rvalid, 1'b1);
        chk("sim.if_rvalid_early", if_rvalid, 1'b0);
        chk("sim.stall_fetch_wait", stall, 1'b1);
        d_req = 1'b0;
        next_cycle();
        settle();
        chk("sim.gap_mem_req", mem_req, 1'b0);
        next_cycle();
        mem_ready = 1'b1;
        settle();
        chk("sim.i_mem_req", mem_req, 1'b1);
        chk("sim.i_mem_we", mem_we, 1'b0);
        chk("sim.i_mem_addr", mem_addr, 32'h8);
        chk("sim.i_mem_ctrl", mem_ctrl, 3'b010);
        next_cycle();
        mem_ready = 1'b0;
        settle();
        chk("sim.if_rvalid", if_rvalid, 1'b1);
        chk("sim.if_rdata", if_rdata, 32'h0000_0113);
        last_i = 32'h0000_0113;
        if_req = 1'b0;
        next_cycle();

        // Starvation: fetch held high against back-to-back loads.
        clear_inputs();
        d_we = 1'b0; d_addr = 32'h40; d_ctrl = LW; if_addr = 32'h80;
        mem_rdata = 32'h0000_1234;
        ng = 0; prev = 1'b0; seq = '0;
        for (int c = 0; c < 60 && ng < 9; c++) begin
            d_req  = 1'b1;
            if_req = 1'b1;
            mem_ready = prev;
            settle();
            if (mem_req && !prev) begin
                seq[ng] = (mem_addr == 32'h80);
                ng++;
            end
            prev = mem_req;
            if (d_rvalid) d_req = 1'b0;
            if (if_rvalid) if_req = 1'b0;
            next_cycle();
        end
        chk("starve.grant_count", ng, 9);
        chk("starve.grant_order", seq, 9'b0_0001_0000);

        // Reset during the in-flight load, with the streak saturated.
        rst = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        settle();
        chk("midrst.stall", stall, 1'b0);
        next_cycle();
        rst = 1'b1;
        clear_inputs();
        settle();
        chk("midrst.mem_req", mem_req, 1'b0);
        chk("midrst.d_rvalid", d_rvalid, 1'b0);
        chk("midrst.if_rvalid", if_rvalid, 1'b0);
        chk("midrst.d_rdata", d_rdata, 32'h0);
        chk("midrst.if_rdata", if_rdata, 32'h0);
        chk("midrst.mem_addr", mem_addr, 32'h0);
        next_cycle();
        settle();
        chk("midrst.no_late_rvalid", d_rvalid, 1'b0);
        chk("midrst.idle_mem_req", mem_req, 1'b0);
        next_cycle();
        d_req = 1'b1; d_addr = 32'h40; d_ctrl = LW;
        if_req = 1'b1; if_addr = 32'h80;
        next_cycle();
        settle();
        chk("midrst.streak_cleared", mem_addr, 32'h40);
        next_cycle();
        do_reset();

        // Randomized traffic against a memory array and the arbitration rules.
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        act = 0; resp = 0; streak = 0; busy_n = 0;
        ip = 1'b0; dp = 1'b0; dwe = 1'b0; ewe = 1'b0;
        ia = '0; da = '0; dwd = '0; ea = '0; ewd = '0; dctl = LW; ectl = LW;
        for (int c = 0; c < 3000; c++) begin
            if (resp == 1) ip = 1'b0;
            else if (!ip && $urandom_range(0, 2) == 0) begin
                ip = 1'b1;
                ia = 32'($urandom_range(0, 15)) << 2;
            end
            if (resp == 2) dp = 1'b0;
            else if (!dp && $urandom_range(0, 2) == 0) begin
                dp   = 1'b1;
                dwe  = 1'($urandom_range(0, 1));
                da   = 32'($urandom_range(0, 15)) << 2;
                dwd  = $urandom;
                dctl = dwe ? SW : LW;
            end
            if_req = ip; if_addr = ia;
            d_req = dp; d_we = dwe; d_addr = da; d_wdata = dwd; d_ctrl = dctl;
            if (act != 0) mem_ready = ($urandom_range(0, 2) == 0) || (busy_n >= 5);
            else mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = (act != 0 && !ewe) ? mem[ea[5:2]] : $urandom;
            settle();
            chk("rnd.mem_req", mem_req, (act != 0));
            if (act != 0) begin
                chk("rnd.mem_addr", mem_addr, ea);
                chk("rnd.mem_we", mem_we, ewe);
                chk("rnd.mem_ctrl", mem_ctrl, ectl);
                if (ewe) chk("rnd.mem_wdata", mem_wdata, ewd);
            end
            chk("rnd.if_rvalid", if_rvalid, (resp == 1));
            chk("rnd.d_rvalid", d_rvalid, (resp == 2));
            chk("rnd.stall", stall, ((ip && resp != 1) || (dp && resp != 2)));
            chk("rnd.if_rdata", if_rdata, last_i);
            chk("rnd.d_rdata", d_rdata, last_d);
            chk("rnd.err", err, 1'b0);
            if (resp != 0) begin
                resp = 0;
            end else if (act != 0) begin
                if (mem_ready) begin
                    if (ewe) mem[ea[5:2]] = ewd;
                    else if (act == 1) last_i = mem[ea[5:2]];
                    else last_d = mem[ea[5:2]];
                    resp = act;
                    act  = 0;
                end else begin
                    busy_n++;
                end
            end else if (dp && !(ip && streak == MAXS)) begin
                act = 2; ea = da; ewe = dwe; ewd = dwd; ectl = dctl; busy_n = 0;
                streak = ip ? ((streak < MAXS) ? streak + 1 : streak) : 0;
            end else if (ip) begin
                act = 1; ea = ia; ewe = 1'b0; ectl = LW; busy_n = 0; streak = 0;
            end
            next_cycle();
        end

`ifdef ARB_TIMEOUT_EN
        // Fetch that never sees mem_ready.
        do_reset();
        if_req = 1'b1; if_addr = 32'h10;
        lat = -1;
        for (int k = 0; k < 30 && lat < 0; k++) begin
            settle();
            if (if_rvalid) lat = k;
            else next_cycle();
        end
        chk("tmo.latency", lat, TOC + 1);
        chk("tmo.if_rdata", if_rdata, 32'h0000_0013);
        chk("tmo.mem_req", mem_req, 1'b0);
        chk("tmo.err", err, 1'b1);
        if_req = 1'b0;
        next_cycle();
        d_req = 1'b1; d_addr = 32'h20; d_ctrl = LW;
        next_cycle();
        mem_ready = 1'b1; mem_rdata = 32'h55;
        next_cycle();
        mem_ready = 1'b0;
        settle();
        chk("tmo.after_d_rvalid", d_rvalid, 1'b1);
        chk("tmo.after_d_rdata", d_rdata, 32'h55);
        chk("tmo.err_sticky", err, 1'b1);
        d_req = 1'b0;
        next_cycle();
        do_reset();
        settle();
        chk("tmo.err_reset", err, 1'b0);
`else
        settle();
        chk("err_tied_low", err, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
